rand63_checker: RTL
===================

Name: rand63_checker

Overview:
- Receive-side checker for the 16-bit parallel 63-bit-LFSR random stream used by the automaton's collision randomiser.
- Holds its own copy of the generator state, seeded with the same 63-bit seed.
- Advances that copy once per valid received word and compares each word against the prediction.
- Reports lock, mismatches and word counts; used in-system as a health monitor and in benches as the scoreboard for the generator.

Parameters:
- CNT_W, 32, width of word_count.
- ERR_W, 16, width of err_count.
- LOCK_N, 8, consecutive matching words before `locked` asserts (1..255).
- ERR_LIMIT, 255, err_count value at which the checker enters FAIL and stops checking.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- seed_in  input  63 ([63:1])  seed, identical to the generator's seed.
- start  input  1  one-cycle pulse: load seed_in, clear counters and status.
- rand_in  input  16  received random word.
- rand_valid  input  1  rand_in holds one generator word this cycle.
- locked  output  1  LOCK_N or more consecutive matches since the last mismatch or start.
- err_flag  output  1  sticky: at least one mismatch since start.
- err_count  output  ERR_W  mismatching words, saturating.
- word_count  output  CNT_W  words checked, saturating.
- seed_err  output  1  the last start carried an all-zero seed.
- state_out  output  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; model state=0; all outputs 0.
- Model: sixteen 4-bit nibbles s1..s16, bits [4:1].
  - Load: s_k = seed_in[4k:4k-3] for k=1..15; s16 = {0, seed_in[63:61]}.
  - Predicted word: {s1[3], s2[3], ..., s16[3]}, with s1[3] as bit 15.
  - Advance: s_k <= {s_k[3:1], fb_k}.
    - fb_1 = s16[3]^s15[3]
    - fb_2 = s16[3]^s1[4]
    - fb_k = s_(k-2)[4]^s_(k-1)[4] for k=3..16
  - The model advances only on an accepted word (rand_valid=1 in ARMED or RUN). Gaps in rand_valid are legal.
- FSM states: IDLE=0, ARMED=1, RUN=2, FAIL=3.
  - IDLE: rand_valid is ignored.
    - start with a nonzero seed -> ARMED.
    - start with an all-zero seed -> stays IDLE, seed_err=1.
  - ARMED: model freshly loaded. First valid word is compared against the load-time prediction -> RUN.
  - RUN: each valid word is compared, then the model advances.
  - FAIL: entered in the same cycle err_count reaches ERR_LIMIT. Comparisons stop; counters and flags hold until start or reset.
- start in any state:
  - Reloads the model; clears err_count, word_count, err_flag, locked and the match-run counter.
  - seed_err is set to (seed_in==0) and cleared otherwise; next state follows the IDLE rules.
  - start and rand_valid in the same cycle: start wins and the word is discarded.
- Per accepted word, all updates are registered one cycle after the rand_valid edge:
  - word_count increments, saturating at all-ones.
  - Mismatch: err_count increments (saturating), err_flag=1, run counter=0, locked=0.
  - Match: run counter increments (saturating at LOCK_N); locked=1 once the run counter reaches LOCK_N.
- The model update and the compare use the pre-advance state in the same cycle. No extra pipeline stage.

Decomposition:
- Shared package hpp_rand_pkg holds:
  - the FSM state encoding constants;
  - the seed-to-nibble load mapping;
  - the next-state function and the word-extract function for the 16x4 LFSR, reused by the generator testbench model.
- One sub-module: rand63_model (load, advance_en, seed; outputs the predicted word). The checker FSM and counters wrap it.

Test Plan:
- seed=63'h4, start, then feed 16'h8000 then 16'h0000 with rand_valid -> both words match; word_count=2, err_count=0, state=RUN.
- Feed LOCK_N matching words from an instance of the generator seeded identically -> locked=1 one cycle after the 8th word; err_flag=0.
- Flip bit 0 of the 20th word -> err_count=1, err_flag=1, locked=0 next cycle. Following correct words relock after 8 more.
- start with seed_in=0 -> seed_err=1, state stays IDLE, valid words ignored (word_count=0).
- ERR_LIMIT=3, feed 5 corrupted words -> err_count=3, state=FAIL, word_count=3 and holds; start returns to ARMED with all counters 0.
- Assert start and rand_valid together mid-RUN, and pulse reset mid-RUN -> word discarded, counters cleared. Reset forces IDLE with all outputs 0 asynchronously.

Source files
------------

// File: rtl/hpp_rand_pkg.sv
// rtl/hpp_rand_pkg.sv - shared definitions for the 16x4 nibble 63-bit LFSR random stream
//
// Purpose: FSM state encoding of the receive-side checker, plus the seed load
// mapping, next-state and word-extract functions of the 16-lane LFSR.
// State vector layout: nibble s_k (k=1..16) occupies bits [4k-1:4k-4], so bit
// s_k[j] (j=1..4) sits at index 4(k-1)+(j-1).
package hpp_rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAIL  = 2'd3
  } chk_state_t;

  // s_k = seed[4k:4k-3] for k=1..15 and s16 = {0, seed[63:61]}. With the
  // packed layout this is the seed shifted down by one with a zero on top.
  function automatic logic [63:0] lfsr_load(input logic [63:1] seed);
    return {1'b0, seed};
  endfunction

  // Word bit 15 comes from s1[3], bit 0 from s16[3].
  function automatic logic [15:0] lfsr_word(input logic [63:0] st);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      w[15-k] = st[4*k+2];
    end
    return w;
  endfunction

  // Each nibble shifts up by one and takes its feedback bit into s_k[1].
  function automatic logic [63:0] lfsr_next(input logic [63:0] st);
    logic [63:0] n;
    n = '0;
    for (int k = 0; k < 16; k++) begin
      n[4*k+1 +: 3] = st[4*k +: 3];
    end
    n[0] = st[62] ^ st[58];       // s16[3] ^ s15[3]
    n[4] = st[62] ^ st[3];        // s16[3] ^ s1[4]
    for (int k = 2; k < 16; k++) begin
      n[4*k] = st[4*(k-2)+3] ^ st[4*(k-1)+3];
    end
    return n;
  endfunction

endpackage

// File: rtl/rand63_model.sv
// rtl/rand63_model.sv - local copy of the 63-bit LFSR generator state
//
// Purpose: holds the predicted generator state; loads from the seed or
// advances one step per accepted word.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (state cleared to 0)
//   load       load state from seed (has priority over advance_en)
//   advance_en advance the LFSR by one word
//   seed       63-bit seed [63:1]
//   pred       predicted word for the current state
module rand63_model
  import hpp_rand_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance_en,
  input  logic [63:1] seed,
  output logic [15:0] pred
);

  logic [63:0] st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= '0;
    end else if (load) begin
      st <= lfsr_load(seed);
    end else if (advance_en) begin
      st <= lfsr_next(st);
    end
  end

  assign pred = lfsr_word(st);

endmodule

// File: rtl/rand63_checker.sv
// rtl/rand63_checker.sv - receive-side checker for the 16-bit parallel 63-bit LFSR stream
//
// Purpose: predicts each received word with a local LFSR copy, and reports
// lock, mismatches and word counts.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   seed_in      seed [63:1], same as the generator's
//   start        pulse: reload model, clear counters and status
//   rand_in      received word, qualified by rand_valid
//   locked       LOCK_N+ consecutive matches since last mismatch or start
//   err_flag     sticky mismatch flag
//   err_count    saturating mismatch count
//   word_count   saturating checked-word count
//   seed_err     last start carried an all-zero seed
//   state_out    FSM state (IDLE/ARMED/RUN/FAIL)
module rand63_checker
  import hpp_rand_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int ERR_W     = 16,
  parameter int LOCK_N    = 8,
  parameter int ERR_LIMIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:1]      seed_in,
  input  logic             start,
  input  logic [15:0]      rand_in,
  input  logic             rand_valid,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             seed_err,
  output logic [1:0]       state_out
);

  localparam logic [7:0]       LOCK_V    = 8'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_LIM_V = ERR_W'(ERR_LIMIT);

  chk_state_t       state, state_nxt;
  logic [7:0]       run_cnt;
  logic [7:0]       run_cnt_inc;
  logic [ERR_W-1:0] err_count_inc;
  logic [15:0]      pred;
  logic             seed_zero;
  logic             accept;
  logic             mism;

  assign seed_zero = (seed_in == '0);
  // start wins over a coincident word, which is simply dropped
  assign accept    = rand_valid && !start && (state == ST_ARMED || state == ST_RUN);
  assign mism      = (rand_in != pred);

  assign err_count_inc = (err_count == '1) ? err_count : err_count + 1'b1;
  assign run_cnt_inc   = (run_cnt == LOCK_V) ? run_cnt : run_cnt + 8'd1;

  rand63_model u_model (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .advance_en (accept),
    .seed       (seed_in),
    .pred       (pred)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = seed_zero ? ST_IDLE : ST_ARMED;
    end else if (accept) begin
      // FAIL is entered on the very word that brings err_count to the limit
      if (mism && (err_count_inc == ERR_LIM_V)) begin
        state_nxt = ST_FAIL;
      end else begin
        state_nxt = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked     <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      seed_err   <= 1'b0;
      run_cnt    <= '0;
    end else if (start) begin
      locked     <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      seed_err   <= seed_zero;
      run_cnt    <= '0;
    end else if (accept) begin
      if (word_count != '1) begin
        word_count <= word_count + 1'b1;
      end
      if (mism) begin
        err_count <= err_count_inc;
        err_flag  <= 1'b1;
        run_cnt   <= '0;
        locked    <= 1'b0;
      end else begin
        run_cnt <= run_cnt_inc;
        locked  <= (run_cnt_inc == LOCK_V);
      end
    end
  end

  assign state_out = state;

endmodule
